// File: rtl/mul32_seq.sv
// mul32_seq -- sequential unsigned shift-and-add multiplier.
//
// Multiplies two WIDTH-bit unsigned operands into an exact 2*WIDTH-bit
// product. It performs one WIDTH-bit add per cycle for WIDTH cycles, then
// spends one cycle publishing the result.
//
// Ports
//   clk    in   1          system clock, rising edge
//   rst    in   1          synchronous active-high reset
//   start  in   1          request a multiply (ignored while busy)
//   A      in   WIDTH      multiplicand, sampled on an accepted start
//   B      in   WIDTH      multiplier, sampled on an accepted start
//   busy   out  1          high while iterating
//   done   out  1          one-cycle pulse when P/ovf update
//   P      out  2*WIDTH    product, held until the next completion
//   ovf    out  1          upper WIDTH bits of P are nonzero
module mul32_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;

  // Datapath registers: no reset, they are always reloaded on acceptance.
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   add;
  logic             load;
  logic             last;

  // The carry-out of the add lands in add[WIDTH]. The right shift moves it
  // into hi's MSB, so the product register's carry bit is always zero
  // afterwards and is not stored.
  always_comb begin
    add  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    load = start && ((state == S_IDLE) || (state == S_DONE));
    last = (cnt == CW'(WIDTH - 1));
  end

  // Datapath: operand load or one shift-add iteration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load) begin
        mcand <= A;
        hi    <= '0;
        lo    <= B;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        hi    <= add[WIDTH:1];
        lo    <= {add[0], lo[WIDTH-1:1]};
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (last) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          P    <= {hi, lo};
          ovf  <= |hi;
          done <= 1'b1;
          // A start here begins the next operation without an idle gap.
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul32_seq.sv
// tb_mul32_seq -- directed self-checking bench for mul32_seq at WIDTH=32.
module tb_mul32_seq;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;
  logic           ovf;

  int nchk = 0;
  int nerr = 0;

  mul32_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation with a single-cycle start pulse, then watch 37
  // cycles. The accepting edge precedes sample cycle 0, so busy must be
  // seen on 32 samples and done only on sample 33.
  task automatic mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [63:0] exp_p, input logic exp_ovf);
    int nbusy;
    int ndone;
    int dcyc;
    logic [63:0] prev_p;
    nbusy  = 0;
    ndone  = 0;
    dcyc   = -1;
    prev_p = P;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc <= 36; cyc++) begin
      if (cyc == 0) begin
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        check({tag, "_phold"}, P, prev_p);
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        dcyc = cyc;
        check({tag, "_p"}, P, exp_p);
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
      end
      @(negedge clk);
    end
    check({tag, "_busycyc"}, 64'(nbusy), 64'd32);
    check({tag, "_ndone"}, 64'(ndone), 64'd1);
    check({tag, "_latency"}, 64'(dcyc), 64'd33);
  endtask

  initial begin
    int nbusy;
    int ndone;
    int dcyc;
    int dcyc2;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_p", P, 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    mul("m3x5", 32'd3, 32'd5, 64'd15, 1'b0);
    mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    mul("m0", 32'd0, 32'h1234_5678, 64'd0, 1'b0);
    mul("m1", 32'h1234_5678, 32'd1, 64'h0000_0000_1234_5678, 1'b0);

    // Start while busy must be ignored.
    @(negedge clk);
    A = 32'd7; B = 32'd9; start = 1'b1;
    @(negedge clk);
    nbusy = 0; ndone = 0; dcyc = -1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc == 0) start = 1'b0;
      if (cyc == 10) begin A = 32'd2; B = 32'd2; start = 1'b1; end
      if (cyc == 11) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin ndone++; dcyc = cyc; end
      @(negedge clk);
    end
    check("busy_ign_p", P, 64'd63);
    check("busy_ign_busycyc", 64'(nbusy), 64'd32);
    check("busy_ign_ndone", 64'(ndone), 64'd1);
    check("busy_ign_latency", 64'(dcyc), 64'd33);

    // Reset mid-run discards the operation.
    @(negedge clk);
    A = 32'd100; B = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_p", P, 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_nodone", 64'(ndone), 64'd0);
    check("midrst_p_after", P, 64'd0);
    mul("m6x7", 32'd6, 32'd7, 64'd42, 1'b0);

    // start held high: back-to-back operations accepted at each DONE cycle.
    @(negedge clk);
    A = 32'h0001_0000; B = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    ndone = 0; dcyc = -1; dcyc2 = -1;
    for (int cyc = 0; cyc <= 72; cyc++) begin
      if (done) begin
        ndone++;
        if (cyc == 33) begin
          check("b2b_p1", P, 64'h0000_0001_0000_0000);
          check("b2b_ovf1", 64'(ovf), 64'd1);
          dcyc = cyc;
        end else if (cyc == 66) begin
          check("b2b_p2", P, 64'd25);
          check("b2b_ovf2", 64'(ovf), 64'd0);
          dcyc2 = cyc;
        end
      end
      if (cyc == 32) begin A = 32'd5; B = 32'd5; end
      if (cyc == 65) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_ndone", 64'(ndone), 64'd2);
    check("b2b_done1_cyc", 64'(dcyc), 64'd33);
    check("b2b_done2_cyc", 64'(dcyc2), 64'd66);
    check("b2b_idle_busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
